// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: sampled VGA stream in, recovered coordinates and lock status out
interface vga_sync_decoder_if;
  logic pix_en;
  logic hs;
  logic vs;
  logic [11:0] colour_in;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic pix_valid;
  logic [11:0] colour_out;
  logic locked;
  logic frame_start;
  logic err;
  logic [7:0] err_count;
  modport master(
    output pix_en, hs, vs, colour_in,
    input pix_x, pix_y, pix_valid, colour_out, locked, frame_start, err, err_count
  );
  modport slave(
    input pix_en, hs, vs, colour_in,
    output pix_x, pix_y, pix_valid, colour_out, locked, frame_start, err, err_count
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: HS/VS loopback monitor recovering pixel coordinates and raster lock; define VGA_SYNC_DECODER_WIDTH_CHECK_EN to also check sync low widths
module vga_sync_decoder #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33
) (
  input logic CLK,
  input logic RESET,
  vga_sync_decoder_if.slave bus
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;
  state_t state, state_n;
  logic hs_d, vs_d, hs_fall, vs_fall, line_bad, frame_bad, win, fs_n, err_n;
  logic [10:0] hcnt, hcnt_n;
  logic [9:0] vcnt, vcnt_n;
  assign hs_fall = hs_d & ~bus.hs;
  assign vs_fall = vs_d & ~bus.vs;
  assign hcnt_n = hs_fall ? 11'd0 : ((&hcnt) ? hcnt : hcnt + 11'd1);
  assign vcnt_n = vs_fall ? 10'd0 : (hs_fall ? vcnt + 10'd1 : vcnt);
  assign frame_bad = vs_fall && (int'(vcnt) + 1 != V_TOTAL);
  // A missing HS fall is flagged once, on the sample where hcnt steps past H_TOTAL.
`ifdef VGA_SYNC_DECODER_WIDTH_CHECK_EN
  assign line_bad = (hs_fall && (int'(hcnt) + 1 != H_TOTAL)) || (!hs_fall && (int'(hcnt) == H_TOTAL)) ||
                    (!hs_d && bus.hs && (int'(hcnt) + 1 != H_SYNC)) || (!vs_d && bus.vs && (int'(vcnt) + 1 != V_SYNC));
`else
  assign line_bad = (hs_fall && (int'(hcnt) + 1 != H_TOTAL)) || (!hs_fall && (int'(hcnt) == H_TOTAL));
`endif
  assign win = int'(hcnt_n) >= H_START && int'(hcnt_n) < H_START + H_VISIBLE &&
               int'(vcnt_n) >= V_START && int'(vcnt_n) < V_START + V_VISIBLE;
  always_comb begin
    state_n = state;
    fs_n = 1'b0;
    err_n = 1'b0;
    if (bus.pix_en)
      case (state)
        SEARCH: state_n = vs_fall ? ALIGN : SEARCH;
        ALIGN: begin
          state_n = line_bad ? SEARCH : ((vs_fall && !frame_bad) ? LOCKED : ALIGN);
          fs_n = !line_bad && vs_fall && !frame_bad;
        end
        LOCKED: begin
          err_n = line_bad || frame_bad;
          state_n = err_n ? SEARCH : LOCKED;
          fs_n = !err_n && vs_fall;
        end
        default: state_n = SEARCH;
      endcase
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= SEARCH;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      hcnt <= '0;
      vcnt <= '0;
      bus.pix_x <= '0;
      bus.pix_y <= '0;
      bus.pix_valid <= 1'b0;
      bus.colour_out <= '0;
      bus.frame_start <= 1'b0;
      bus.err <= 1'b0;
      bus.err_count <= '0;
    end else begin
      state <= state_n;
      bus.frame_start <= fs_n;
      bus.err <= err_n;
      if (err_n && bus.err_count != 8'hff) bus.err_count <= bus.err_count + 8'd1;
      if (bus.pix_en) begin
        hs_d <= bus.hs;
        vs_d <= bus.vs;
        hcnt <= hcnt_n;
        vcnt <= vcnt_n;
        bus.pix_x <= win ? 10'(hcnt_n - 11'(H_START)) : '0;
        bus.pix_y <= win ? 9'(vcnt_n - 10'(V_START)) : '0;
        bus.pix_valid <= win && state_n == LOCKED;
        bus.colour_out <= bus.colour_in;
      end
    end
  assign bus.locked = state == LOCKED;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: reduced-size raster with random blanking colour and strobe gaps, checked against a rule-level decoder model
module tb_vga_sync_decoder;
  localparam int HV = 16, HF = 2, HSW = 4, HB = 3, VV = 8, VF = 1, VSW = 2, VB = 2;
  localparam int HT = HV + HF + HSW + HB, VT = VV + VF + VSW + VB;
  localparam int HST = HSW + HB, VST = VSW + VB;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int tests = 0, fails = 0;
  vga_sync_decoder_if bus();
  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  longint sidx, hf;
  int nl, st, e_x, e_y, e_cnt, cur_frame;
  bit hd, vd, e_valid, e_fs, e_err, rnd_gap;
  logic [11:0] e_col;
  int fs_cnt[20], val_cnt[20];
  bit lk[20];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, want, $time);
    end
  endtask
  task automatic model_reset();
    st = 0; hf = sidx - 1; nl = 0; hd = 1; vd = 1;
    e_valid = 0; e_x = 0; e_y = 0; e_col = '0; e_fs = 0; e_err = 0; e_cnt = 0;
  endtask
  // st: 0 searching, 1 aligning, 2 locked; lengths are sample distances between sync falls
  task automatic model_step(input bit h, input bit v, input logic [11:0] c);
    bit hfall, vfall, lv, badf, win;
    int len, hc;
    hfall = hd && !h;
    vfall = vd && !v;
    len = (sidx - hf > 2048) ? 2048 : int'(sidx - hf);
    lv = (hfall && len != HT) || (!hfall && len == HT + 1);
`ifdef VGA_SYNC_DECODER_WIDTH_CHECK_EN
    lv = lv || (!hd && h && len != HSW) || (!vd && v && nl + 1 != VSW);
`endif
    badf = vfall && nl + 1 != VT;
    e_fs = 0;
    e_err = 0;
    if (st == 2 && (lv || badf)) begin
      st = 0; e_err = 1;
      if (e_cnt < 255) e_cnt++;
    end else if (st == 2 && vfall) e_fs = 1;
    else if (st == 1 && lv) st = 0;
    else if (st == 1 && vfall && !badf) begin
      st = 2; e_fs = 1;
    end else if (st == 0 && vfall) st = 1;
    if (hfall) hf = sidx;
    if (vfall) nl = 0;
    else if (hfall) nl++;
    hc = (sidx - hf > 2047) ? 2047 : int'(sidx - hf);
    win = hc >= HST && hc < HST + HV && nl >= VST && nl < VST + VV;
    e_x = win ? hc - HST : 0;
    e_y = win ? nl - VST : 0;
    e_valid = win && st == 2;
    e_col = c;
    hd = h;
    vd = v;
    sidx++;
  endtask
  task automatic check_all(input bit pe);
    chk("locked", bus.locked, st == 2);
    chk("pix_valid", bus.pix_valid, e_valid);
    chk("pix_x", bus.pix_x, e_x);
    chk("pix_y", bus.pix_y, e_y);
    chk("colour_out", bus.colour_out, e_col);
    chk("frame_start", bus.frame_start, pe && e_fs);
    chk("err", bus.err, pe && e_err);
    chk("err_count", bus.err_count, e_cnt);
    if (pe) begin
      fs_cnt[cur_frame] += int'(bus.frame_start);
      val_cnt[cur_frame] += int'(bus.pix_valid);
      if (e_valid && (e_x == 0 || e_x == HV - 1) && (e_y == 0 || e_y == VV - 1))
        chk("corner_colour", bus.colour_out, {e_y[3:0], e_x[7:0]});
    end
  endtask
  task automatic tick(input bit pe, input bit h, input bit v, input logic [11:0] c);
    @(negedge CLK);
    bus.pix_en = pe; bus.hs = h; bus.vs = v; bus.colour_in = c;
    if (pe) model_step(h, v, c);
    @(posedge CLK);
    #1;
    check_all(pe);
  endtask
  task automatic samp(input bit h, input bit v, input logic [11:0] c);
    int g;
    g = rnd_gap ? int'($urandom_range(1, 4)) : 4;
    repeat (g - 1) tick(0, h, v, c);
    tick(1, h, v, c);
  endtask
  task automatic line(input int y, input int len, input int hlow);
    for (int x = 0; x < len; x++) begin
      int px, py;
      px = x - HST;
      py = y - VST;
      samp(x >= hlow, y >= VSW, (px >= 0 && px < HV && py >= 0 && py < VV) ? 12'({py[3:0], px[7:0]}) : 12'($urandom));
      if (x == 0 && y == 0) lk[cur_frame] = bus.locked;
    end
  endtask
  task automatic frame(input int k, input int y0, input int y1, input int short_y, input int narrow_y);
    cur_frame = k;
    for (int y = y0; y <= y1; y++) line(y, y == short_y ? HT - 1 : HT, y == narrow_y ? HSW - 1 : HSW);
  endtask
  initial begin
    bus.pix_en = 0; bus.hs = 1; bus.vs = 1; bus.colour_in = '0;
    sidx = 0; rnd_gap = 0; cur_frame = 0;
    model_reset();
    repeat (3) tick(0, 1, 1, 12'habc);
    RESET = 1'b0;
    frame(0, 5, VT - 1, -1, -1);
    for (int k = 1; k <= 3; k++) frame(k, 0, VT - 1, -1, -1);
    chk("lock_frame1", lk[1], 0);
    chk("lock_frame2", lk[2], 1);
    chk("fs_frame2", fs_cnt[2], 1);
    chk("fs_frame3", fs_cnt[3], 1);
    chk("valid_frame2", val_cnt[2], HV * VV);
    chk("valid_frame3", val_cnt[3], HV * VV);
    frame(4, 0, VT - 1, 6, -1);
    chk("short_err_count", bus.err_count, 1);
    chk("short_locked", bus.locked, 0);
    frame(5, 0, VT - 1, -1, -1);
    frame(6, 0, VT - 1, -1, -1);
    chk("relock_frame5", lk[5], 0);
    chk("relock_frame6", lk[6], 1);
    frame(7, 0, 4, -1, -1);
    repeat (HT + 15) samp(1, 1, 12'($urandom));
    chk("timeout_err_count", bus.err_count, 2);
    chk("timeout_locked", bus.locked, 0);
    rnd_gap = 1;
    for (int k = 8; k <= 11; k++) frame(k, 0, VT - 1, -1, -1);
    rnd_gap = 0;
    chk("rnd_lock_frame9", lk[9], 1);
    chk("rnd_fs_frame10", fs_cnt[10], 1);
    chk("rnd_fs_frame11", fs_cnt[11], 1);
    chk("rnd_valid_frame11", val_cnt[11], HV * VV);
    frame(12, 0, VT - 1, -1, 3);
`ifdef VGA_SYNC_DECODER_WIDTH_CHECK_EN
    chk("narrow_locked", bus.locked, 0);
    chk("narrow_err_count", bus.err_count, 3);
`else
    chk("narrow_locked", bus.locked, 1);
    chk("narrow_err_count", bus.err_count, 2);
`endif
    frame(13, 0, 5, -1, -1);
    line(6, 10, HSW);
    #2 RESET = 1'b1;
    model_reset();
    #1 check_all(0);
    repeat (2) tick(0, 1, 1, 12'h5a5);
    RESET = 1'b0;
    frame(13, 7, VT - 1, -1, -1);
    frame(14, 0, VT - 1, -1, -1);
    frame(15, 0, VT - 1, -1, -1);
    chk("reset_relock_frame14", lk[14], 0);
    chk("reset_relock_frame15", lk[15], 1);
    chk("reset_err_count", bus.err_count, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
